// File: rtl/seven_segments_pkg.sv
// Shared types, segment constants and conversion helpers for the two-digit display driver.
// Segment patterns here are active-high, bit order gfedcba.
package seven_segments_pkg;

  typedef logic [6:0] seg_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;

  localparam seg_t SEG_DASH  = seg_t'(1 << SEG_G);
  localparam seg_t SEG_BLANK = 7'h00;

  // Any digit code above 9 renders as a dash; this one is used to force it.
  localparam logic [3:0] CODE_DASH = 4'hF;

  function automatic seg_t digit_pattern(input logic [3:0] code);
    seg_t pat;
    case (code)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  // Compare/subtract split; exact over the full 7-bit range (tens reaches 12 at 127).
  function automatic bcd_t bin_to_bcd(input logic [6:0] bin);
    bcd_t       res;
    logic [6:0] rem;
    rem      = bin;
    res.tens = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (rem >= 7'd10) begin
        rem      = rem - 7'd10;
        res.tens = res.tens + 4'd1;
      end
    end
    res.ones = rem[3:0];
    return res;
  endfunction

endpackage

// File: rtl/seven_segments_digit.sv
// Combinational 4-bit digit code to 7-segment pattern; codes 10..15 show a dash.
// ACTIVE_LOW=1 inverts the pattern so a 0 bit lights the segment.
module seven_segments_digit
  import seven_segments_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  seg_t pattern;

  always_comb begin
    pattern = digit_pattern(digit_i);
    seg_o   = ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/seven_segments_bcd.sv
// Two-digit decimal display driver: tens on o_Segment1, ones on o_Segment2, one-cycle latency.
// Optional SEG_LEAD_ZERO_BLANK_EN blanks the tens digit for values 0..9.
module seven_segments_bcd
  import seven_segments_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned MAX_VALUE  = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] counter,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2
);

  localparam seg_t SEG_OFF = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  bcd_t       bcd;
  logic       overflow;
  logic       lead_blank;
  logic [3:0] tens_code;
  logic [3:0] ones_code;
  seg_t       tens_seg;
  seg_t       ones_seg;
  seg_t       seg1_d, seg1_q;
  seg_t       seg2_d, seg2_q;

  always_comb begin
    bcd       = bin_to_bcd(counter);
    overflow  = (32'(counter) > MAX_VALUE);
    tens_code = overflow ? CODE_DASH : bcd.tens;
    ones_code = overflow ? CODE_DASH : bcd.ones;
`ifdef SEG_LEAD_ZERO_BLANK_EN
    lead_blank = !overflow && (bcd.tens == 4'd0);
`else
    lead_blank = 1'b0;
`endif
  end

  seven_segments_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_tens (
    .digit_i (tens_code),
    .seg_o   (tens_seg)
  );

  seven_segments_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_ones (
    .digit_i (ones_code),
    .seg_o   (ones_seg)
  );

  always_comb begin
    seg1_d = lead_blank ? SEG_OFF : tens_seg;
    seg2_d = ones_seg;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg1_q <= SEG_OFF;
      seg2_q <= SEG_OFF;
    end else begin
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
    end
  end

  assign o_Segment1 = seg1_q;
  assign o_Segment2 = seg2_q;

endmodule

// File: tb/tb_seven_segments_bcd.sv
// Scoreboard bench for seven_segments_bcd: stimulus pushes expected patterns, a monitor pops and compares.
// Reference model uses plain divide/modulo over the digit table.
module tb_seven_segments_bcd;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] counter = 7'd0;
  logic [6:0] seg1, seg2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s2;
    int         v;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  localparam logic [6:0] HI_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_segments_bcd dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .counter    (counter),
    .o_Segment1 (seg1),
    .o_Segment2 (seg2)
  );

  always #20 clk = ~clk;

  // Board default is active-low: lit segment = 0.
  function automatic logic [6:0] lit(input logic [6:0] hi);
    return ~hi;
  endfunction

  function automatic exp_t model(input int v);
    exp_t e;
    e.v = v;
    if (v > 99) begin
      e.s1 = lit(7'h40);
      e.s2 = lit(7'h40);
    end else begin
      e.s1 = lit(HI_TAB[v / 10]);
      e.s2 = lit(HI_TAB[v % 10]);
`ifdef SEG_LEAD_ZERO_BLANK_EN
      if (v <= 9) e.s1 = 7'h7F;
`endif
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input int v);
    @(negedge clk);
    counter = 7'(v);
    q.push_back(model(v));
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check($sformatf("seg1 v=%0d", mon_e.v), seg1, mon_e.s1);
      check($sformatf("seg2 v=%0d", mon_e.v), seg2, mon_e.s2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    counter = 7'd42;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset seg1", seg1, 7'h7F);
    check("reset seg2", seg2, 7'h7F);
    rst_n = 1'b1;
    q.push_back(model(42));
    @(posedge clk); #5;
    check("release seg1", seg1, 7'h19);
    check("release seg2", seg2, 7'h24);

    for (int i = 0; i <= 99; i++) drive(i);
    @(posedge clk); #5;
    check("spot99 seg1", seg1, 7'h10);
    check("spot99 seg2", seg2, 7'h10);
    drive(57);
    @(posedge clk); #5;
    check("spot57 seg1", seg1, 7'h12);
    check("spot57 seg2", seg2, 7'h78);

    drive(100);
    drive(127);
    @(posedge clk); #5;
    check("ovf127 seg1", seg1, 7'h3F);
    check("ovf127 seg2", seg2, 7'h3F);

    for (int i = 0; i < 200; i++) drive(int'($urandom_range(0, 127)));
    for (int i = 0; i < 4; i++) drive(33);

    drive(12);
    @(posedge clk); #5;
    counter = 7'd88;
    q.push_back(model(88));
    #10;
    check("latency hold seg1", seg1, 7'h79);
    check("latency hold seg2", seg2, 7'h24);
    @(posedge clk); #5;
    check("latency seg1", seg1, 7'h00);
    check("latency seg2", seg2, 7'h00);

    drive(63);
    @(posedge clk); #5;
    rst_n = 1'b0;
    #1;
    check("async rst seg1", seg1, 7'h7F);
    check("async rst seg2", seg2, 7'h7F);
    @(posedge clk); #2;
    check("rst hold seg1", seg1, 7'h7F);
    check("rst hold seg2", seg2, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(int'($urandom_range(0, 127)));

`ifdef SEG_LEAD_ZERO_BLANK_EN
    drive(5);
    @(posedge clk); #5;
    check("blank5 seg1", seg1, 7'h7F);
    check("blank5 seg2", seg2, 7'h12);
    drive(10);
    @(posedge clk); #5;
    check("blank10 seg1", seg1, 7'h79);
    check("blank10 seg2", seg2, 7'h40);
`else
    drive(7);
    @(posedge clk); #5;
    check("lead0 seg1", seg1, 7'h40);
    check("lead0 seg2", seg2, 7'h78);
`endif

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #5;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
